cplx_alu_scheduler: RTL
=======================

Name: cplx_alu_scheduler

Overview:
Sequences one shared combinational 4-bit multiplier and one shared 4-bit adder/subtractor to execute complex add, sub and mul instructions for two independent requesters. A 2-way round-robin arbiter selects the requester; the FSM then time-multiplexes the multiplier (4 products) and the adder (2 sums) and returns the result over a valid/ready response port. It sits between the instruction sources and the existing multiplier/adder units, replacing the fixed pipeline sequencing.

Parameters:
DATA_W, 4, width of each real/imag operand and result part
INSTR_W, 2+4*DATA_W, instruction width, derived, not overridable

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  2  per-requester request valid
req_instr0  in  INSTR_W  requester 0 instruction
req_instr1  in  INSTR_W  requester 1 instruction
req_ready  out  2  per-requester accept, combinational, one-hot or zero
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester index of result
rsp_real  out  DATA_W  real part
rsp_imag  out  DATA_W  imaginary part
rsp_err  out  1  illegal opcode flag
mult_a, mult_b  out  DATA_W  shared multiplier operands
mult_p  in  DATA_W  multiplier product (low DATA_W bits, combinational)
add_a, add_b  out  DATA_W  shared adder operands
add_sub  out  1  1 = add_a - add_b, 0 = add_a + add_b
add_y  in  DATA_W  adder result (combinational)
busy  out  1  FSM not in IDLE
ops_done  out  8  completed-response counter

Behaviour:
- Instruction fields: [INSTR_W-1:INSTR_W-2] opcode; then a, b, c, d (DATA_W each, MSB to LSB). Operands are (a+bi), (c+di).
- Opcodes: 00 add -> (a+c, b+d); 01 sub -> (a-c, b-d); 10 mul -> (ac-bd, ad+bc); 11 illegal. All arithmetic modulo 2^DATA_W.
- Reset (async): state IDLE, rr pointer 0, rsp_valid 0, rsp_id 0, rsp_real/imag 0, rsp_err 0, ops_done 0, product regs 0. An in-flight op is discarded; no response is produced.
- States: IDLE, MUL0, MUL1, MUL2, MUL3, ADD_RE, ADD_IM, DONE.
- IDLE: if any req_valid, assert req_ready for the arbiter winner only; latch instr and id on that edge.
  - mul -> MUL0; add/sub -> ADD_RE; illegal -> DONE with err=1, results 0.
  - Arbiter: the pointer requester has priority. After each grant the pointer moves to the other requester. A lone requester always wins.
- MUL0..MUL3: drive (a,c), (b,d), (a,d), (b,c); register mult_p into p0..p3; advance one state per cycle. MUL3 -> ADD_RE.
- ADD_RE: add/sub: add_a=a, add_b=c, add_sub=opcode[0]. mul: add_a=p0, add_b=p1, add_sub=1. Register add_y as real.
- ADD_IM: add/sub: b, d, add_sub=opcode[0]. mul: p2, p3, add_sub=0. Register imag. -> DONE.
- DONE: rsp_valid=1; rsp_id/real/imag/err stable until rsp_ready. On rsp_valid&&rsp_ready: ops_done+1 (wraps 255->0), -> IDLE.
  - No request is accepted in DONE.
  - Back-to-back minimum is one IDLE cycle between ops.
- Latency from accept edge to rsp_valid high: add/sub 3 cycles, mul 7 cycles, illegal 1 cycle.
- Outside its active states, mult_a/mult_b/add_a/add_b/add_sub are driven 0.
- req_ready is 0 whenever state != IDLE, even if req_valid is held.
- A requester dropping req_valid before grant is legal; no accept occurs.

Decomposition:
- Package cplx_alu_pkg: opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_ILL), state encoding, field-slice offsets as functions of DATA_W.
- One sub-module, rr_arb2: 2-way round-robin arbiter; inputs req[1:0], advance; outputs grant[1:0]; owns the pointer and the async reset.

Test Plan:
- Add: req0 instr {00,2,3,5,7} -> after 3 cycles rsp_valid, real=7, imag=10 (0xA), id=0, err=0; ops_done=1.
- Sub/mul: req1 {01,2,3,5,1} -> (13,2). req0 {10,1,2,3,4} -> 7 cycles, (11,10).
  - Check mult_a/mult_b sequence (1,3),(2,4),(1,4),(2,3).
  - Check ADD_RE add_sub=1, ADD_IM add_sub=0.
- Contention: both req_valid high continuously after reset -> grants alternate 0,1,0,1. rsp_id follows the same order. req_ready never high for both.
- Backpressure: hold rsp_ready low 5 cycles in DONE -> outputs stable, req_ready=0, ops_done unchanged; on release ops_done increments once.
- Illegal and reset:
  - Opcode 11 -> rsp_valid 1 cycle after accept, err=1, real=imag=0.
  - Assert reset during MUL2 -> busy, rsp_valid drop immediately (async), no response later, next request accepted normally from req0.

Source files
------------

// File: rtl/cplx_alu_pkg.sv
// cplx_alu_pkg: opcodes, FSM state encoding and instruction field offsets shared by the complex ALU scheduler.
package cplx_alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, ADD_RE, ADD_IM, DONE} state_t;

    function automatic int op_lsb(input int dw);
        return 4 * dw;
    endfunction

    function automatic int a_lsb(input int dw);
        return 3 * dw;
    endfunction

    function automatic int b_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int c_lsb(input int dw);
        return dw;
    endfunction

    function automatic int d_lsb(input int dw);
        return 0 * dw;
    endfunction
endpackage

// File: rtl/cplx_alu_scheduler_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; the pointer requester wins ties and the pointer
// moves to the requester that was not granted after every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic ptr;

    assign grant = ptr ? (req[1] ? 2'b10 : req[0] ? 2'b01 : 2'b00)
                       : (req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ptr <= 1'b0;
        else if (advance) ptr <= ~grant[1];
    end
endmodule

// File: rtl/cplx_alu_scheduler.sv
// cplx_alu_scheduler: runs complex add/sub/mul for two requesters by time-multiplexing
// one external multiplier (four products) and one external adder (two sums).
module cplx_alu_scheduler
    import cplx_alu_pkg::*;
#(
    parameter  int DATA_W  = 4,
    localparam int INSTR_W = 2 + 4 * DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         req_valid,
    input  logic [INSTR_W-1:0] req_instr0,
    input  logic [INSTR_W-1:0] req_instr1,
    output logic [1:0]         req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [DATA_W-1:0]  rsp_real,
    output logic [DATA_W-1:0]  rsp_imag,
    output logic               rsp_err,
    output logic [DATA_W-1:0]  mult_a,
    output logic [DATA_W-1:0]  mult_b,
    input  logic [DATA_W-1:0]  mult_p,
    output logic [DATA_W-1:0]  add_a,
    output logic [DATA_W-1:0]  add_b,
    output logic               add_sub,
    input  logic [DATA_W-1:0]  add_y,
    output logic               busy,
    output logic [7:0]         ops_done
);
    state_t             state, state_nx;
    logic [INSTR_W-1:0] instr, sel_instr;
    logic               id;
    logic [DATA_W-1:0]  p [4];
    logic [1:0]         grant, arb_req, op, sel_op;
    logic [DATA_W-1:0]  op_a, op_b, op_c, op_d;
    logic               is_mul;

    assign arb_req   = (state == IDLE) ? req_valid : 2'b00;
    assign req_ready = grant;
    assign sel_instr = grant[1] ? req_instr1 : req_instr0;
    assign sel_op    = sel_instr[op_lsb(DATA_W) +: 2];
    assign op        = instr[op_lsb(DATA_W) +: 2];
    assign op_a      = instr[a_lsb(DATA_W) +: DATA_W];
    assign op_b      = instr[b_lsb(DATA_W) +: DATA_W];
    assign op_c      = instr[c_lsb(DATA_W) +: DATA_W];
    assign op_d      = instr[d_lsb(DATA_W) +: DATA_W];
    assign is_mul    = (op == OP_MUL);
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_id    = id;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (|grant),
        .grant   (grant)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|grant) state_nx = (sel_op == OP_MUL) ? MUL0 : (sel_op == OP_ILL) ? DONE : ADD_RE;
            MUL0:    state_nx = MUL1;
            MUL1:    state_nx = MUL2;
            MUL2:    state_nx = MUL3;
            MUL3:    state_nx = ADD_RE;
            ADD_RE:  state_nx = ADD_IM;
            ADD_IM:  state_nx = DONE;
            DONE:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Product order p0..p3 = ac, bd, ad, bc so that re = p0 - p1 and im = p2 + p3.
    always_comb begin
        mult_a  = '0;
        mult_b  = '0;
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        case (state)
            MUL0: begin mult_a = op_a; mult_b = op_c; end
            MUL1: begin mult_a = op_b; mult_b = op_d; end
            MUL2: begin mult_a = op_a; mult_b = op_d; end
            MUL3: begin mult_a = op_b; mult_b = op_c; end
            ADD_RE: begin
                add_a   = is_mul ? p[0] : op_a;
                add_b   = is_mul ? p[1] : op_c;
                add_sub = is_mul | op[0];
            end
            ADD_IM: begin
                add_a   = is_mul ? p[2] : op_b;
                add_b   = is_mul ? p[3] : op_d;
                add_sub = ~is_mul & op[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            instr    <= '0;
            id       <= 1'b0;
            p        <= '{default: '0};
            rsp_real <= '0;
            rsp_imag <= '0;
            rsp_err  <= 1'b0;
            ops_done <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && |grant) begin
                instr    <= sel_instr;
                id       <= grant[1];
                rsp_err  <= (sel_op == OP_ILL);
                rsp_real <= '0;
                rsp_imag <= '0;
            end
            if (state inside {MUL0, MUL1, MUL2, MUL3}) p[2'(state - MUL0)] <= mult_p;
            if (state == ADD_RE) rsp_real <= add_y;
            if (state == ADD_IM) rsp_imag <= add_y;
            if (state == DONE && rsp_ready) ops_done <= ops_done + 8'd1;
        end
    end
endmodule
